// File: rtl/exec_unit_pipe.sv
// Execute stage for a Y86-64 style pipeline. It computes the ALU and address
// result, evaluates the branch or move condition, and keeps the condition-code
// register. Multiply uses a shift-add FSM, one step per cycle.
//
// Handshake: an operation is taken on a rising edge where in_valid && in_ready.
// A result is presented with out_valid and is held unchanged until a rising edge
// where out_valid && out_ready. in_ready is 1 only while the FSM is IDLE and the
// output register is empty or is being consumed on this edge. That keeps at most
// one operation in flight, so the next operation always sees the condition codes
// written by the operation before it.
module exec_unit_pipe #(
  parameter int WIDTH      = 64,
  parameter int MUL_EN     = 1,
  parameter int STACK_STEP = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic [WIDTH-1:0] val_c,
  input  logic             cc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             cnd,
  output logic [2:0]       cc_out,
  output logic             out_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] val_e_q, val_e_d;
  logic             cnd_q, cnd_d;
  logic             err_q, err_d;
  logic [2:0]       cc_q, cc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_cc_en_q, mul_cc_en_d;

  logic             accept;
  logic [WIDTH-1:0] sum_c, diff_c, res_c, step_acc;
  logic             err_c, cnd_c, cc_wr_c, is_mul_c, of_c, cond_c, lt_c, last_step;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == BUSY);
  assign out_valid = out_valid_q;
  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign out_err   = err_q;
  assign cc_out    = cc_q;

  assign sum_c     = val_b + val_a;
  assign diff_c    = val_b - val_a;
  assign step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Decode the offered operation: result, condition, error, and CC write enable.
  always_comb begin
    res_c    = '0;
    err_c    = 1'b0;
    cnd_c    = 1'b0;
    cc_wr_c  = 1'b0;
    is_mul_c = 1'b0;
    of_c     = 1'b0;
    lt_c     = cc_q[1] ^ cc_q[0];
    case (ifun)
      4'd0:    cond_c = 1'b1;
      4'd1:    cond_c = lt_c | cc_q[2];
      4'd2:    cond_c = lt_c;
      4'd3:    cond_c = cc_q[2];
      4'd4:    cond_c = !cc_q[2];
      4'd5:    cond_c = !lt_c;
      4'd6:    cond_c = !lt_c && !cc_q[2];
      default: cond_c = 1'b0;
    endcase
    case (icode)
      4'h2: begin
        if (ifun > 4'd6) err_c = 1'b1;
        else begin
          res_c = val_a;
          cnd_c = cond_c;
        end
      end
      4'h3: res_c = val_c;
      4'h4, 4'h5: res_c = val_b + val_c;
      4'h6: begin
        case (ifun)
          4'd0: begin
            res_c   = sum_c;
            of_c    = (val_a[WIDTH-1] == val_b[WIDTH-1]) && (sum_c[WIDTH-1] != val_b[WIDTH-1]);
            cc_wr_c = cc_en;
          end
          4'd1: begin
            res_c   = diff_c;
            of_c    = (val_a[WIDTH-1] != val_b[WIDTH-1]) && (diff_c[WIDTH-1] != val_b[WIDTH-1]);
            cc_wr_c = cc_en;
          end
          4'd2: begin
            res_c   = val_b & val_a;
            cc_wr_c = cc_en;
          end
          4'd3: begin
            res_c   = val_b ^ val_a;
            cc_wr_c = cc_en;
          end
          4'd4: begin
            if (MUL_EN != 0) is_mul_c = 1'b1;
            else             err_c    = 1'b1;
          end
          default: err_c = 1'b1;
        endcase
      end
      4'h7: begin
        if (ifun > 4'd6) err_c = 1'b1;
        else             cnd_c = cond_c;
      end
      4'h8, 4'hA: res_c = val_b - WIDTH'(STACK_STEP);
      4'h9, 4'hB: res_c = val_b + WIDTH'(STACK_STEP);
      4'hC, 4'hD, 4'hE, 4'hF: err_c = 1'b1;
      default: res_c = '0;
    endcase
  end

  // FSM next state: a multiply parks the unit in BUSY for WIDTH shift-add steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul_c) state_d = BUSY;
      BUSY:    if (last_step)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the output, condition-code and multiplier registers.
  always_comb begin
    out_valid_d = out_valid_q;
    val_e_d     = val_e_q;
    cnd_d       = cnd_q;
    err_d       = err_q;
    cc_d        = cc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_cc_en_d = mul_cc_en_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (is_mul_c) begin
        mcand_d     = val_b;
        mplier_d    = val_a;
        acc_d       = '0;
        cnt_d       = '0;
        mul_cc_en_d = cc_en;
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        val_e_d     = res_c;
        cnd_d       = cnd_c;
        err_d       = err_c;
        if (cc_wr_c) cc_d = {res_c == '0, res_c[WIDTH-1], of_c};
      end
    end
    if (state_q == BUSY) begin
      // Low WIDTH bits of the product are the same for signed and unsigned.
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_step) begin
        out_valid_d = 1'b1;
        val_e_d     = step_acc;
        cnd_d       = 1'b0;
        err_d       = 1'b0;
        if (mul_cc_en_q) cc_d = {step_acc == '0, step_acc[WIDTH-1], 1'b0};
      end
    end
  end

  // State and datapath registers; reset abandons any multiply in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      val_e_q     <= '0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      cc_q        <= 3'b100;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_cc_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      val_e_q     <= val_e_d;
      cnd_q       <= cnd_d;
      err_q       <= err_d;
      cc_q        <= cc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_cc_en_q <= mul_cc_en_d;
    end
  end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Bench for exec_unit_pipe: directed cases plus randomized traffic. Results are
// predicted by an arithmetic model and compared in order by a monitor.
module tb_exec_unit_pipe;

  localparam int W    = 64;
  localparam int STEP = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   icode = '0;
  logic [3:0]   ifun = '0;
  logic [W-1:0] val_a = '0;
  logic [W-1:0] val_b = '0;
  logic [W-1:0] val_c = '0;
  logic         cc_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] val_e;
  logic         cnd;
  logic [2:0]   cc_out;
  logic         out_err;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] v;
    logic         c;
    logic         e;
    logic [2:0]   cc;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] model_cc = 3'b100;
  int         rdy_mode = 2;   // 0 random, 1 hold low, 2 always high

  exec_unit_pipe #(.WIDTH(W), .MUL_EN(1), .STACK_STEP(STEP)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .val_a(val_a), .val_b(val_b), .val_c(val_c),
    .cc_en(cc_en), .out_valid(out_valid), .out_ready(out_ready), .val_e(val_e),
    .cnd(cnd), .cc_out(cc_out), .out_err(out_err), .busy(busy)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream ready, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural meaning of each instruction, using wide
  // signed arithmetic for overflow and products.
  task automatic predict(input logic [3:0] ic, input logic [3:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] cv, input logic ce,
                         output exp_t e);
    logic signed [W+1:0]   sa, sb, tr, rr;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          r;
    logic zf, sf, of, lt, c, bad, nof;
    zf = model_cc[2]; sf = model_cc[1]; of = model_cc[0]; lt = sf ^ of;
    case (f)
      4'd0: c = 1'b1;
      4'd1: c = lt | zf;
      4'd2: c = lt;
      4'd3: c = zf;
      4'd4: c = !zf;
      4'd5: c = !lt;
      4'd6: c = !lt && !zf;
      default: c = 1'b0;
    endcase
    bad = (ic >= 12) || ((ic == 2 || ic == 7) && f > 6) || (ic == 6 && f > 4);
    e.v = '0; e.c = 1'b0; e.e = bad;
    if (!bad) begin
      case (ic)
        4'h2: begin e.v = a; e.c = c; end
        4'h7: e.c = c;
        4'h3: e.v = cv;
        4'h4, 4'h5: e.v = b + cv;
        4'h8, 4'hA: e.v = b - W'(STEP);
        4'h9, 4'hB: e.v = b + W'(STEP);
        4'h6: begin
          sa = $signed(a); sb = $signed(b); nof = 1'b0; r = '0;
          case (f)
            4'd0: begin tr = sb + sa; r = tr[W-1:0]; rr = $signed(r); nof = (tr != rr); end
            4'd1: begin tr = sb - sa; r = tr[W-1:0]; rr = $signed(r); nof = (tr != rr); end
            4'd2: r = b & a;
            4'd3: r = b ^ a;
            default: begin prod = $signed(b) * $signed(a); r = prod[W-1:0]; end
          endcase
          e.v = r;
          if (ce) model_cc = {r == '0, r[W-1], nof};
        end
        default: e.v = '0;
      endcase
    end
    e.cc = model_cc;
  endtask

  // Driver: offer one operation and push its prediction when it is accepted.
  task automatic issue_op(input logic [3:0] ic, input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] cv, input logic ce);
    exp_t e;
    int   n;
    @(negedge clock);
    icode = ic; ifun = f; val_a = a; val_b = b; val_c = cv; cc_en = ce;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    predict(ic, f, a, b, cv, ce, e);
    exp_q.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("wait_out_valid", W'(out_valid), W'(1));
  endtask

  // Monitor / scoreboard: compare every consumed result in order.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %h with no expected entry", val_e);
      end else begin
        e = exp_q.pop_front();
        chk("sb_val_e", val_e, e.v);
        chk("sb_cnd", W'(cnd), W'(e.c));
        chk("sb_out_err", W'(out_err), W'(e.e));
        chk("sb_cc_out", W'(cc_out), W'(e.cc));
      end
    end
  end

  initial begin : main
    int busy_cyc, lat, bad_rdy, saw;
    logic [3:0]   ric, rf;
    logic [W-1:0] ra, rb;

    // Reset: offer an op while reset is held; nothing may be accepted.
    in_valid = 1'b1; icode = 4'h6; ifun = 4'h0; val_a = 64'd1; val_b = 64'd1; cc_en = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_val_e", val_e, '0);
    chk("rst_cnd", W'(cnd), W'(0));
    chk("rst_out_err", W'(out_err), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_cc_out", W'(cc_out), W'(3'b100));
    @(negedge clock);
    in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_no_accept", W'(out_valid), W'(0));

    // Subtract to zero, then jumps on equal / not equal.
    issue_op(4'h6, 4'h1, 64'd5, 64'd5, '0, 1'b1);
    wait_valid();
    chk("sub_val_e", val_e, '0);
    chk("sub_cc", W'(cc_out), W'(3'b100));
    issue_op(4'h7, 4'h3, '0, '0, '0, 1'b0);
    wait_valid();
    chk("je_cnd", W'(cnd), W'(1));
    issue_op(4'h7, 4'h4, '0, '0, '0, 1'b0);
    wait_valid();
    chk("jne_cnd", W'(cnd), W'(0));

    // Signed overflow on add, then conditional moves.
    issue_op(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 1'b1);
    wait_valid();
    chk("add_ovf_val_e", val_e, 64'h8000_0000_0000_0000);
    chk("add_ovf_cc", W'(cc_out), W'(3'b011));
    issue_op(4'h2, 4'h2, 64'hAA, '0, '0, 1'b0);
    wait_valid();
    chk("cmovl_cnd", W'(cnd), W'(0));
    issue_op(4'h2, 4'h5, 64'hAA, '0, '0, 1'b0);
    wait_valid();
    chk("cmovge_cnd", W'(cnd), W'(1));

    // Stack and address arithmetic; OPq with cc_en=0.
    issue_op(4'hA, 4'h0, '0, 64'h100, '0, 1'b0);
    wait_valid();
    chk("pushq_val_e", val_e, 64'hF8);
    issue_op(4'hB, 4'h0, '0, 64'h100, '0, 1'b0);
    wait_valid();
    chk("popq_val_e", val_e, 64'h108);
    issue_op(4'h4, 4'h0, '0, 64'h10, 64'h20, 1'b0);
    wait_valid();
    chk("rmmovq_val_e", val_e, 64'h30);
    issue_op(4'h6, 4'h1, 64'd9, 64'd9, '0, 1'b0);
    wait_valid();
    chk("cc_en0_cc", W'(cc_out), W'(3'b011));

    // Multiply: -3 * 7.
    issue_op(4'h6, 4'h4, 64'd7, -64'sd3, '0, 1'b1);
    busy_cyc = 0; lat = 0; bad_rdy = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (busy) busy_cyc++;
      if (busy && in_ready) bad_rdy++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("mul_busy_cycles", W'(busy_cyc), W'(64));
    chk("mul_latency", W'(lat), W'(65));
    chk("mul_in_ready_while_busy", W'(bad_rdy), W'(0));
    chk("mul_val_e", val_e, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_cc", W'(cc_out), W'(3'b010));

    // Backpressure: result held for 3 cycles, no new acceptance.
    @(negedge clock);
    rdy_mode = 1;
    issue_op(4'h6, 4'h3, 64'hF0, 64'hFF, '0, 1'b1);
    wait_valid();
    @(negedge clock);
    icode = 4'h3; ifun = 4'h0; val_c = 64'h77; cc_en = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("hold_val_e", val_e, 64'h0F);
      chk("hold_out_valid", W'(out_valid), W'(1));
      chk("hold_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    rdy_mode = 2;

    // Illegal OPq function.
    issue_op(4'h6, 4'h7, 64'd3, 64'd4, '0, 1'b1);
    wait_valid();
    chk("bad_ifun_err", W'(out_err), W'(1));
    chk("bad_ifun_val_e", val_e, '0);

    // Randomized traffic with random backpressure.
    rdy_mode = 0;
    repeat (300) begin
      ric = ($urandom_range(0, 9) < 4) ? 4'h6 : 4'($urandom_range(0, 15));
      if (ric == 4'h6)                    rf = 4'($urandom_range(0, 5));
      else if (ric == 4'h2 || ric == 4'h7) rf = 4'($urandom_range(0, 8));
      else                                rf = 4'($urandom_range(0, 15));
      if (ric == 4'h6 && rf == 4'h4 && $urandom_range(0, 2) != 0) rf = 4'h0;
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = W'($urandom_range(0, 15));
        default: rb = {$urandom, $urandom};
      endcase
      issue_op(ric, rf, ra, rb, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    rdy_mode = 2;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clock);
    chk("drain_queue_empty", W'(exp_q.size()), W'(0));

    // Reset in the middle of a multiply.
    issue_op(4'h6, 4'h4, 64'd5, 64'd6, '0, 1'b1);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_cc", W'(cc_out), W'(3'b100));
    exp_q.delete();
    model_cc = 3'b100;
    @(negedge clock);
    reset_n = 1'b1;
    saw = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (out_valid) saw++;
    end
    chk("mid_rst_no_result", W'(saw), W'(0));
    issue_op(4'h3, 4'h0, '0, '0, 64'h55, 1'b0);
    wait_valid();
    chk("post_rst_irmovq", val_e, 64'h55);
    chk("post_rst_cc", W'(cc_out), W'(3'b100));
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    chk("final_queue_empty", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_unit_pipe.md
EXEC_UNIT_PIPE -- requirements
Module: exec_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits (>=8).
REQ-002 SHALL have parameter MUL_EN, default 1, enabling OPq ifun 4 (multiply).
REQ-003 SHALL have parameter STACK_STEP, default 8, stack pointer adjust for call/ret/push/pop.
REQ-004 SHALL have ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  unit accepts the operation this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- val_a, val_b, val_c  in  WIDTH  operands.
- cc_en  in  1  operation may update condition codes (0 for squashed/bubbled ops).
- out_valid  out  1  result registered and held.
- out_ready  in  1  downstream consumes the result.
- val_e  out  WIDTH  result.
- cnd  out  1  condition outcome.
- cc_out  out  3  {ZF,SF,OF} current condition-code register.
- out_err  out  1  invalid icode/ifun for the accepted operation.
- busy  out  1  multiply in progress.

Function
REQ-005 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1; in_ready = (state==IDLE) and (!out_valid or out_ready).
REQ-006 SHALL register the result of single-cycle ops so out_valid is 1 the cycle after acceptance (latency 1).
REQ-007 SHALL hold val_e, cnd, out_err stable while out_valid=1 and out_ready=0; out_valid clears on out_ready unless a new op is accepted the same edge.
REQ-008 SHALL compute val_e by icode: 2 cmovXX val_a; 3 irmovq val_c; 4 rmmovq, 5 mrmovq val_b+val_c; 6 OPq per REQ-009; 8 call, A pushq val_b-STACK_STEP; 9 ret, B popq val_b+STACK_STEP; 0, 1, 7 -> 0.
REQ-009 SHALL compute OPq: ifun 0 val_b+val_a, 1 val_b-val_a, 2 val_b&val_a, 3 val_b^val_a, 4 low WIDTH bits of signed val_b*val_a (MUL_EN=1 only); all arithmetic modulo 2^WIDTH.
REQ-010 SHALL set flags for OPq: ZF = result==0; SF = result[WIDTH-1]; OF: add = operands same sign and result sign differs; sub = val_b, val_a signs differ and result sign differs from val_b; and/xor/mul = 0.
REQ-011 SHALL update the CC register on the edge the OPq result is registered, only if cc_en was 1 at acceptance and out_err=0; no other icode updates CC.
REQ-012 SHALL evaluate cnd for icode 2 and 7 from the CC register value at acceptance: ifun 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; all other icodes cnd=0.
REQ-013 SHALL set out_err=1, val_e=0, cnd=0, no CC update for: icode 12-15, icode 2/7 with ifun>6, icode 6 with ifun>4, icode 6 ifun 4 when MUL_EN=0.
REQ-014 SHALL implement multiply as an FSM IDLE -> BUSY -> IDLE: enter BUSY on acceptance of OPq ifun 4, iterate one shift-add step per cycle for WIDTH cycles, then register the result (out_valid at acceptance+WIDTH+1) and return to IDLE.
REQ-015 SHALL drive busy=1 exactly while state==BUSY; in_ready=0 while busy.
REQ-016 SHALL let a back-to-back op see CC updated by the immediately preceding OPq (no hazard bubble).

Reset
REQ-017 SHALL, on reset_n low, asynchronously force: state IDLE, out_valid 0, val_e 0, cnd 0, out_err 0, busy 0, cc_out {ZF,SF,OF} = 3'b100.
REQ-018 SHALL abort an in-progress multiply on reset with no result emitted and no CC update.
REQ-019 SHALL accept no operation on the first rising edge at which reset_n is low; operation resumes on the first edge after reset_n is sampled high.

Verification
REQ-020 OPq sub val_b=5, val_a=5, cc_en=1 -> val_e=0, cc_out=100; then jXX ifun 3 -> cnd=1, ifun 4 -> cnd=0.
REQ-021 OPq add val_b=0x7FFF_FFFF_FFFF_FFFF, val_a=1 -> val_e=0x8000_0000_0000_0000, cc_out=011; next cmovXX ifun 2 -> cnd=0, ifun 5 -> cnd=1.
REQ-022 OPq mul val_b=-3, val_a=7 -> busy 64 cycles, in_ready=0 throughout, out_valid at acceptance+65, val_e=-21, cc_out=010.
REQ-023 pushq val_b=0x100 -> val_e=0xF8; popq val_b=0x100 -> 0x108; rmmovq val_b=0x10, val_c=0x20 -> 0x30; OPq with cc_en=0 -> cc_out unchanged.
REQ-024 out_ready held 0 for 3 cycles after a result -> val_e stable, in_ready=0, no new acceptance; icode 6 ifun 7 -> out_err=1, val_e=0.
REQ-025 reset_n pulsed low mid-multiply (cycle 10) -> busy=0, out_valid=0, cc_out=100 immediately; no result after release.
